// File: rtl/axi_mst_pkg.sv
// Shared constants, types and region decode helpers for the AXI burst master.
package axi_mst_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] ID_MEM = 4'd1;
    localparam logic [3:0] ID_DMA = 4'd2;
    localparam logic [3:0] ID_AES = 4'd3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] RESP_OKAY   = 2'd0;

    typedef enum logic [3:0] {
        TGT_MEM = 4'd0,
        TGT_DMA = 4'd1,
        TGT_AES = 4'd2
    } tgt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_e;

    // Reads always fetch a full line; only writes are shaped by the region.
    function automatic logic [7:0] tgt_len(input logic [3:0] t, input logic we,
                                           input int unsigned beats,
                                           input int unsigned dma_beats);
        logic [7:0] len;
        len = 8'(beats - 1);
        if (we) begin
            case (t)
                TGT_MEM: len = 8'(beats - 1);
                TGT_DMA: len = 8'(dma_beats - 1);
                default: len = 8'd0;
            endcase
        end
        return len;
    endfunction

    function automatic logic [1:0] tgt_burst(input logic [3:0] t, input logic we);
        return (we && t == TGT_AES) ? BURST_FIXED : BURST_INCR;
    endfunction

    function automatic logic [3:0] tgt_id(input logic [3:0] t, input logic we);
        logic [3:0] id;
        id = ID_MEM;
        if (we) begin
            case (t)
                TGT_MEM: id = ID_MEM;
                TGT_DMA: id = ID_DMA;
                TGT_AES: id = ID_AES;
                default: id = 4'd0;
            endcase
        end
        return id;
    endfunction

endpackage

// File: rtl/axi_mst_beat_ctr.sv
// Beat counter shared by the R and W phases: clears on load, counts handshakes,
// saturates at max_val and remembers that the final slot has been consumed.
module axi_mst_beat_ctr
    import axi_mst_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] max_val,
    output logic [CNT_W-1:0] count,
    output logic             last,
    output logic             full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
        end else if (load) begin
            count <= '0;
            full  <= 1'b0;
        end else if (inc) begin
            if (count == max_val) begin
                full <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign last = (count == max_val);

endmodule

// File: rtl/axi_burst_master.sv
// Cache-line to AXI4 burst master, one transaction outstanding at a time.
// Define AXI_MST_RESP_ERR_EN to add the sticky response-error flag (err_o / err_clr_i).
module axi_burst_master
    import axi_mst_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned DMA_BEATS = 3,
    parameter int unsigned TGT_LSB   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cs_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [LINE_W-1:0]   wdata_i,
    output logic                busy_o,
    output logic [LINE_W-1:0]   rdata_o,
    output logic                rvalid_o,
    output logic                wdone_o,
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [7:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic [7:0]          arlen_o,
    output logic [2:0]          arsize_o,
    output logic [1:0]          arburst_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o
`ifdef AXI_MST_RESP_ERR_EN
    ,
    input  logic                err_clr_i,
    output logic                err_o
`endif
);

    localparam int unsigned BEATS  = LINE_W / DATA_W;
    localparam logic [2:0]  SIZE   = 3'($clog2(DATA_W / 8));

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic                we_q;
    logic [7:0]          len_q;
    logic [1:0]          burst_q;
    logic [ID_W-1:0]     id_q;
    logic [CNT_W-1:0]    beat_q;
    logic [CNT_W-1:0]    beat_max;
    logic                beat_last;
    logic                beat_full;
    logic                accept;
    logic                w_hs;
    logic                r_hs;
    logic [3:0]          tgt;
    logic                unused_ok;

    assign tgt    = addr_i[TGT_LSB+3:TGT_LSB];
    assign accept = (state_q == ST_IDLE) && cs_i;
    assign w_hs   = wvalid_o && wready_i;
    assign r_hs   = rready_o && rvalid_i;

    // Reads saturate at the line size even if the slave sends a longer burst.
    assign beat_max = we_q ? len_q[CNT_W-1:0] : CNT_W'(BEATS - 1);

    axi_mst_beat_ctr u_beat_ctr (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .load    (accept),
        .inc     (w_hs || r_hs),
        .max_val (beat_max),
        .count   (beat_q),
        .last    (beat_last),
        .full    (beat_full)
    );

    assign busy_o    = (state_q != ST_IDLE);
    assign awid_o    = id_q;
    assign awaddr_o  = addr_q;
    assign awlen_o   = len_q;
    assign awsize_o  = SIZE;
    assign awburst_o = burst_q;
    assign arid_o    = id_q;
    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arsize_o  = SIZE;
    assign arburst_o = burst_q;
    assign wdata_o   = wdata_q[beat_q*DATA_W +: DATA_W];
    assign wstrb_o   = '1;
    assign wlast_o   = wvalid_o && beat_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            len_q     <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            awvalid_o <= 1'b0;
            wvalid_o  <= 1'b0;
            bready_o  <= 1'b0;
            arvalid_o <= 1'b0;
            rready_o  <= 1'b0;
            rvalid_o  <= 1'b0;
            wdone_o   <= 1'b0;
            rdata_o   <= '0;
        end else begin
            rvalid_o <= 1'b0;
            wdone_o  <= 1'b0;
            if (r_hs && !beat_full) begin
                rdata_o[beat_q*DATA_W +: DATA_W] <= rdata_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        we_q    <= we_i;
                        len_q   <= tgt_len(tgt, we_i, BEATS, DMA_BEATS);
                        burst_q <= tgt_burst(tgt, we_i);
                        id_q    <= ID_W'(tgt_id(tgt, we_i));
                        if (we_i) begin
                            awvalid_o <= 1'b1;
                            state_q   <= ST_AW;
                        end else begin
                            arvalid_o <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (awready_i) begin
                        awvalid_o <= 1'b0;
                        wvalid_o  <= 1'b1;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs && beat_last) begin
                        wvalid_o <= 1'b0;
                        bready_o <= 1'b1;
                        state_q  <= ST_B;
                    end
                end
                ST_B: begin
                    if (bvalid_i) begin
                        bready_o <= 1'b0;
                        wdone_o  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid_i && rlast_i) begin
                        rready_o <= 1'b0;
                        rvalid_o <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_MST_RESP_ERR_EN
    // Clear wins over a same-cycle error so software never loses a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end else if ((bvalid_i && bready_o && bresp_i != RESP_OKAY) ||
                     (r_hs && rresp_i != RESP_OKAY)) begin
            err_o <= 1'b1;
        end
    end

    assign unused_ok = ^{rid_i, bid_i};
`else
    assign unused_ok = ^{rid_i, bid_i, bresp_i, rresp_i};
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master acting as the AXI slave; table of requests
// plus hand-written sequences for early/late rlast, back-to-back and mid-burst reset.
module tb_axi_burst_master;
    import axi_mst_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_cs, req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_line;
    logic         busy, line_valid, wdone;
    logic [127:0] line_out;
    logic [3:0]   awid, arid, bid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, r_valid, rready, rlast;
    logic [31:0]  w_data, r_data;
    logic [3:0]   wstrb;
`ifdef AXI_MST_RESP_ERR_EN
    logic         err, err_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] line;
        logic [31:0]  base;
        logic [7:0]   exp_len;
        logic [1:0]   exp_burst;
        logic [3:0]   exp_id;
        bit           stall;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .cs_i      (req_cs),
        .we_i      (req_we),
        .addr_i    (req_addr),
        .wdata_i   (req_line),
        .busy_o    (busy),
        .rdata_o   (line_out),
        .rvalid_o  (line_valid),
        .wdone_o   (wdone),
        .awid_o    (awid),
        .awaddr_o  (awaddr),
        .awlen_o   (awlen),
        .awsize_o  (awsize),
        .awburst_o (awburst),
        .awvalid_o (awvalid),
        .awready_i (awready),
        .wdata_o   (w_data),
        .wstrb_o   (wstrb),
        .wlast_o   (wlast),
        .wvalid_o  (wvalid),
        .wready_i  (wready),
        .bid_i     (bid),
        .bresp_i   (bresp),
        .bvalid_i  (bvalid),
        .bready_o  (bready),
        .arid_o    (arid),
        .araddr_o  (araddr),
        .arlen_o   (arlen),
        .arsize_o  (arsize),
        .arburst_o (arburst),
        .arvalid_o (arvalid),
        .arready_i (arready),
        .rid_i     (rid),
        .rdata_i   (r_data),
        .rresp_i   (rresp),
        .rlast_i   (rlast),
        .rvalid_i  (r_valid),
        .rready_o  (rready)
`ifdef AXI_MST_RESP_ERR_EN
        ,
        .err_clr_i (err_clr),
        .err_o     (err)
`endif
    );

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v, input logic [1:0] resp);
        int n;
        logic [31:0] exp_beat;
        @(negedge clk);
        req_cs = 1'b1; req_we = 1'b1; req_addr = v.addr; req_line = v.line;
        @(negedge clk);
        req_cs = 1'b0;
        n = 0;
        while (!awvalid && n < 16) begin @(negedge clk); n++; end
        check_output("awvalid", awvalid, 1'b1);
        check_output("awaddr", awaddr, v.addr);
        check_output("awlen", awlen, v.exp_len);
        check_output("awburst", awburst, v.exp_burst);
        check_output("awid", awid, v.exp_id);
        check_output("awsize", awsize, 3'd2);
        check_output("busy_w", busy, 1'b1);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        for (int b = 0; b <= int'(v.exp_len); b++) begin
            exp_beat = v.line[b*32 +: 32];
            if (v.stall) begin
                wready = 1'b0;
                check_output("wdata_pre_stall", w_data, exp_beat);
                @(negedge clk);
                check_output("wdata_stalled", w_data, exp_beat);
            end
            check_output("wvalid", wvalid, 1'b1);
            check_output("wdata", w_data, exp_beat);
            check_output("wlast", wlast, b == int'(v.exp_len));
            check_output("wstrb", wstrb, 4'hF);
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
        check_output("wvalid_drop", wvalid, 1'b0);
        check_output("bready", bready, 1'b1);
        bvalid = 1'b1; bresp = resp;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'd0;
        check_output("wdone_pulse", wdone, 1'b1);
        check_output("busy_after_b", busy, 1'b0);
        @(negedge clk);
        check_output("wdone_low", wdone, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] base, input int nbeats,
                           input bit gaps, input logic [127:0] exp_line, input logic [1:0] resp,
                           input bit issue, input bit hold_cs);
        int n;
        if (issue) begin
            @(negedge clk);
            req_cs = 1'b1; req_we = 1'b0; req_addr = a;
            @(negedge clk);
            if (!hold_cs) req_cs = 1'b0;
        end
        n = 0;
        while (!arvalid && n < 16) begin @(negedge clk); n++; end
        check_output("arvalid", arvalid, 1'b1);
        check_output("araddr", araddr, a);
        check_output("arlen", arlen, 8'd3);
        check_output("arburst", arburst, 2'd1);
        check_output("arid", arid, ID_MEM);
        check_output("arsize", arsize, 3'd2);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check_output("arvalid_drop", arvalid, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && (i % 2 == 1)) begin
                r_valid = 1'b0;
                @(negedge clk);
            end
            check_output("rready", rready, 1'b1);
            r_valid = 1'b1; r_data = base + 32'(i); rlast = (i == nbeats - 1); rresp = resp;
            @(negedge clk);
        end
        r_valid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        check_output("rvalid_pulse", line_valid, 1'b1);
        check_output("rdata_line", line_out, exp_line);
        check_output("busy_after_r", busy, 1'b0);
        @(negedge clk);
        check_output("rvalid_low", line_valid, 1'b0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.we) do_write(v, 2'd0);
        else      do_read(v.addr, v.base, 4, v.stall, v.line, 2'd0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0040, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 32'h0, 8'd3, 2'd1, ID_MEM, 1'b0};
        vecs[1] = '{1'b1, 32'h0001_0000, 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000, 32'h0, 8'd2, 2'd1, ID_DMA, 1'b1};
        vecs[2] = '{1'b1, 32'h0002_0010, 128'h9999_9999_8888_8888_7777_7777_CAFE_F00D, 32'h0, 8'd0, 2'd0, ID_AES, 1'b0};
        vecs[3] = '{1'b1, 32'h0007_0004, 128'h0000_0000_0000_0000_0000_0000_5555_AAAA, 32'h0, 8'd0, 2'd1, 4'd0,   1'b0};
        vecs[4] = '{1'b0, 32'h0000_0080, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0, 32'hA0, 8'd3, 2'd1, ID_MEM, 1'b1};
        vecs[5] = '{1'b0, 32'h0001_0040, 128'h0000_0013_0000_0012_0000_0011_0000_0010, 32'h10, 8'd3, 2'd1, ID_MEM, 1'b0};

        rst_n = 1'b0; req_cs = 1'b0; req_we = 1'b0; req_addr = '0; req_line = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; bid = 4'd0;
        arready = 1'b0; r_valid = 1'b0; r_data = '0; rresp = 2'd0; rlast = 1'b0; rid = 4'd0;
`ifdef AXI_MST_RESP_ERR_EN
        err_clr = 1'b0;
`endif
        @(negedge clk);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_awvalid", awvalid, 1'b0);
        check_output("rst_arvalid", arvalid, 1'b0);
        check_output("rst_wvalid", wvalid, 1'b0);
        check_output("rst_rvalid", line_valid, 1'b0);
        check_output("rst_wdone", wdone, 1'b0);
        check_output("rst_rdata", line_out, 128'h0);
        check_output("rst_awaddr", awaddr, 32'h0);
`ifdef AXI_MST_RESP_ERR_EN
        check_output("rst_err", err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

        // Early rlast: upper slices keep the previous line's data
        do_read(32'h0000_0100, 32'hB0, 2, 1'b0,
                128'h0000_0013_0000_0012_0000_00B1_0000_00B0, 2'd0, 1'b1, 1'b0);
        // Overlong burst: beats past the line are dropped
        do_read(32'h0000_0200, 32'hC0, 6, 1'b0,
                128'h0000_00C3_0000_00C2_0000_00C1_0000_00C0, 2'd0, 1'b1, 1'b0);

        // Back-to-back reads with cs held across the IDLE cycle
        do_read(32'h0000_0300, 32'hD0, 4, 1'b0,
                128'h0000_00D3_0000_00D2_0000_00D1_0000_00D0, 2'd0, 1'b1, 1'b1);
        check_output("b2b_busy", busy, 1'b1);
        check_output("b2b_arvalid", arvalid, 1'b1);
        req_cs = 1'b0;
        do_read(32'h0000_0300, 32'hE0, 4, 1'b1,
                128'h0000_00E3_0000_00E2_0000_00E1_0000_00E0, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a write burst, after two beats
        @(negedge clk);
        req_cs = 1'b1; req_we = 1'b1; req_addr = vecs[0].addr; req_line = vecs[0].line;
        @(negedge clk);
        req_cs = 1'b0;
        check_output("mid_awvalid", awvalid, 1'b1);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wready = 1'b0;
        check_output("mid_wdata_beat2", w_data, 32'h3333_3333);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_wvalid", wvalid, 1'b0);
        check_output("mid_rst_awvalid", awvalid, 1'b0);
        check_output("mid_rst_bready", bready, 1'b0);
        check_output("mid_rst_arvalid", arvalid, 1'b0);
        check_output("mid_rst_rready", rready, 1'b0);
        check_output("mid_rst_busy", busy, 1'b0);
        check_output("mid_rst_wlast", wlast, 1'b0);
        check_output("mid_rst_rdata", line_out, 128'h0);
        check_output("mid_rst_awaddr", awaddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(vecs[0], 2'd0);

`ifdef AXI_MST_RESP_ERR_EN
        do_write(vecs[0], 2'd2);
        check_output("err_set", err, 1'b1);
        @(negedge clk);
        check_output("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("err_cleared", err, 1'b0);
        err_clr = 1'b1;
        do_write(vecs[0], 2'd2);
        err_clr = 1'b0;
        check_output("err_clr_priority", err, 1'b0);
        do_read(32'h0000_0400, 32'hF0, 4, 1'b0,
                128'h0000_00F3_0000_00F2_0000_00F1_0000_00F0, 2'd2, 1'b1, 1'b0);
        check_output("err_rresp", err, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
